mult_arbiter: RTL and testbench

Shares one pipelined signed fixed-point multiplier between `N_REQ` neuron requesters. A round-robin arbiter grants at most one operand pair per cycle. Each product is tagged with its requester's index and is returned after a fixed latency. The block sits between a layer's neurons and the single multiplier resource, so the neuron count no longer sets the DSP count.

---
 rtl/mult_arbiter.sv | 122 ++++++++++++
 tb/tb_mult_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed Q-format multiplier among N_REQ requesters.
// Build option: define MULT_ARBITER_SAT_EN to saturate out-of-range products instead of wrapping.
module mult_arbiter #(
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int NUM_W    = INT_W + FRAC_W,
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][NUM_W-1:0] v1,
  input  logic [N_REQ-1:0][NUM_W-1:0] v2,
  output logic [N_REQ-1:0]            gnt,
  output logic [NUM_W-1:0]            res,
  output logic [N_REQ-1:0]            res_valid,
  output logic                        busy
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PROD_W = 2 * NUM_W;

  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [PTR_W-1:0]                winner;
  logic                            found;
  logic                            accept;
  logic [MULT_LAT-1:0]             valid_q, valid_d;
  logic [MULT_LAT-1:0][PTR_W-1:0]  tag_q, tag_d;
  logic [MULT_LAT-1:0][NUM_W-1:0]  data_q, data_d;
  logic signed [NUM_W-1:0]         op1, op2;
  logic signed [PROD_W-1:0]        prod;
  logic [NUM_W-1:0]                reduced;
  logic                            unused_prod_bits;

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin : p_search
    logic [PTR_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % 32'(N_REQ));
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign accept = found & enable & nreset;

  always_comb begin
    gnt = '0;
    if (accept) gnt[winner] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = PTR_W'((32'(winner) + 32'd1) % 32'(N_REQ));
  end

  // The product slice starting at FRAC_W is the arithmetic (floor) right shift.
  always_comb begin
    op1  = v1[winner];
    op2  = v2[winner];
    prod = PROD_W'(op1) * PROD_W'(op2);
`ifdef MULT_ARBITER_SAT_EN
    unused_prod_bits = ^prod[FRAC_W-1:0];
    if (&prod[PROD_W-1:FRAC_W+NUM_W-1] || ~|prod[PROD_W-1:FRAC_W+NUM_W-1])
      reduced = prod[FRAC_W +: NUM_W];
    else if (prod[PROD_W-1])
      reduced = {1'b1, {(NUM_W-1){1'b0}}};
    else
      reduced = {1'b0, {(NUM_W-1){1'b1}}};
`else
    unused_prod_bits = ^{prod[PROD_W-1:FRAC_W+NUM_W], prod[FRAC_W-1:0]};
    reduced          = prod[FRAC_W +: NUM_W];
`endif
  end

  // Whole pipeline freezes while enable is low, so a stalled result is re-presented.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (enable) begin
      valid_d[0] = accept;
      tag_d[0]   = winner;
      data_d[0]  = accept ? reduced : '0;
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        tag_d[i]   = tag_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q   <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign res  = data_q[MULT_LAT-1];
  assign busy = |valid_q;

  always_comb begin
    res_valid = '0;
    if (enable && valid_q[MULT_LAT-1]) res_valid[tag_q[MULT_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus predicts grants and queues expected tagged products,
// a negedge monitor pops and compares each res_valid pulse, including its enabled-edge latency.
module tb_mult_arbiter;

  localparam int INT_W  = 8;
  localparam int FRAC_W = 8;
  localparam int NUM_W  = 16;
  localparam int N      = 4;
  localparam int LAT    = 2;

  logic                    clk = 1'b0;
  logic                    nreset;
  logic                    enable;
  logic [N-1:0]            req;
  logic [N-1:0][NUM_W-1:0] v1, v2;
  logic [N-1:0]            gnt;
  logic [NUM_W-1:0]        res;
  logic [N-1:0]            res_valid;
  logic                    busy;

  mult_arbiter #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .NUM_W(NUM_W), .N_REQ(N), .MULT_LAT(LAT)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .req(req), .v1(v1), .v2(v2),
    .gnt(gnt), .res(res), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    logic [NUM_W-1:0] data;
    int               cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               checks   = 0;
  int               errors   = 0;
  int               en_edges = 0;
  int               n_pop    = 0;
  int               mptr     = 0;
  logic [NUM_W-1:0] op1[N];
  logic [NUM_W-1:0] op2[N];

  // Q-format product: exact integer product, floor-divided by 2^FRAC_W, then wrapped or clamped.
  function automatic logic [NUM_W-1:0] ref_mul(input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] b);
    longint p, q, scale;
    scale = longint'(1) << FRAC_W;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p / scale;
    if (p < 0 && (p % scale) != 0) q = q - 1;
`ifdef MULT_ARBITER_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[NUM_W-1:0];
  endfunction

  function automatic logic [NUM_W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (nreset === 1'b1 && enable === 1'b1) en_edges++;

  always @(negedge clk) begin
    if (nreset === 1'b1) begin
      if (res_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected res_valid=%b res=%h with nothing in flight", res_valid, res);
        end else begin
          mon_e = sb.pop_front();
          n_pop++;
          if (res_valid !== N'(1 << mon_e.tag) || res !== mon_e.data || en_edges != mon_e.cnt) begin
            errors++;
            $display("FAIL result actual tag=%b res=%h edge=%0d expected tag=%b res=%h edge=%0d",
                     res_valid, res, en_edges, N'(1 << mon_e.tag), mon_e.data, mon_e.cnt);
          end
        end
      end else if (enable === 1'b1 && sb.size() > 0) begin
        checks++;
        if (sb[0].cnt <= en_edges) begin
          errors++;
          $display("FAIL result_missing actual res_valid=%b expected tag=%0d at edge %0d (now %0d)",
                   res_valid, sb[0].tag, sb[0].cnt, en_edges);
        end
      end
    end
  end

  task automatic drive_cycle(input logic [N-1:0] r, input logic en, output int g);
    logic [N-1:0] exp_gnt;
    exp_t         e;
    int           idx;
    @(posedge clk);
    #1;
    req    = r;
    enable = en;
    for (int i = 0; i < N; i++) begin
      v1[i] = op1[i];
      v2[i] = op2[i];
    end
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && r[idx]) g = idx;
      end
    end
    exp_gnt = (g >= 0) ? N'(1 << g) : '0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    if (g >= 0) begin
      e.tag  = g;
      e.data = ref_mul(op1[g], op2[g]);
      e.cnt  = en_edges + LAT;
      sb.push_back(e);
      mptr = (g + 1) % N;
    end
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < 20 && sb.size() > 0; i++) drive_cycle('0, 1'b1, g);
    chk("drain_left", 32'(sb.size()), 32'd0);
    drive_cycle('0, 1'b1, g);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int           g;
    int           base;
    logic [N-1:0] pend;

    nreset = 1'b0;
    enable = 1'b0;
    req    = '0;
    for (int i = 0; i < N; i++) begin
      op1[i] = '0;
      op2[i] = '0;
      v1[i]  = '0;
      v2[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;

    // Single request, then pointer must sit at 3
    op1[2] = 16'h0180; op2[2] = 16'h0200;
    op1[3] = 16'h0100; op2[3] = 16'h0100;
    drive_cycle(4'b0100, 1'b1, g);
    drive_cycle(4'b0000, 1'b1, g);
    drive_cycle(4'b1011, 1'b1, g);

    // Signed products and floor rounding
    op1[0] = 16'hFF00; op2[0] = 16'h0080;
    op1[1] = 16'hFFFF; op2[1] = 16'h0080;
    drive_cycle(4'b0011, 1'b1, g);
    drive_cycle(4'b0010, 1'b1, g);
    drain();

    // Reset with two products in flight
    for (int i = 0; i < N; i++) begin op1[i] = rnd_op(); op2[i] = rnd_op(); end
    drive_cycle(4'b1111, 1'b1, g);
    drive_cycle(4'b1111, 1'b1, g);
    @(posedge clk);
    #1;
    nreset = 1'b0;
    req    = 4'b1111;
    sb.delete();
    mptr = 0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_res", 32'(res), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    req    = '0;
    repeat (4) drive_cycle('0, 1'b1, g);

    // Round robin from pointer 0
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'b1111, 1'b1, g);
      if (g >= 0) begin op1[g] = rnd_op(); op2[g] = rnd_op(); end
    end
    repeat (3) drive_cycle(4'b1010, 1'b1, g);
    drain();

    // Overflow cases
    op1[0] = 16'h6400; op2[0] = 16'h6400;
    op1[1] = 16'h8000; op2[1] = 16'h0200;
    drive_cycle(4'b0001, 1'b1, g);
    drive_cycle(4'b0010, 1'b1, g);
    drain();

    // Stall after the first of three results
    for (int i = 0; i < N; i++) begin op1[i] = rnd_op(); op2[i] = rnd_op(); end
    base = n_pop;
    repeat (3) drive_cycle(4'b1111, 1'b1, g);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b1111, 1'b0, g);
      chk("stall_res_valid", 32'(res_valid), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    chk("stall_pops", 32'(n_pop - base), 32'd1);
    drain();
    chk("stall_total_pops", 32'(n_pop - base), 32'd3);

    // Randomized traffic with occasional stalls
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          op1[i]  = rnd_op();
          op2[i]  = rnd_op();
        end
      end
      drive_cycle(pend, ($urandom_range(0, 9) != 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
